// File: rtl/irq_pending_capture_pkg.sv
// irq_pending_capture_pkg: shared FSM encoding and default line count
package irq_pending_capture_pkg;

    localparam int N_DEFAULT = 4;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/irq_pending_capture_if.sv
// irq_pending_capture_if: valid/ready index channel from capture stage to encoder
//   valid  master->slave  idx holds a pending request
//   ready  slave->master  consumer accepts when valid & ready
//   idx    master->slave  index of the presented request
interface irq_pending_capture_if
    import irq_pending_capture_pkg::*;
#(
    parameter int N = N_DEFAULT
);
    localparam int W = $clog2(N);
    logic         valid;
    logic         ready;
    logic [W-1:0] idx;
    modport master (output valid, output idx, input ready);
    modport slave  (input valid, input idx, output ready);
endinterface

// File: rtl/prio_pick_n.sv
// prio_pick_n: highest set index of an N-bit vector plus any-set flag
//   i_vec  in   N  candidate vector
//   o_idx  out  W  highest set bit index (0 when none set)
//   o_any  out  1  at least one bit set
module prio_pick_n #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] i_vec,
    output logic [W-1:0] o_idx,
    output logic         o_any
);
    always_comb begin
        o_idx = '0;
        o_any = |i_vec;
        for (int i = 0; i < N; i++)
            if (i_vec[i]) o_idx = W'(i);
    end
endmodule

// File: rtl/irq_pending_capture.sv
// irq_pending_capture: masked rising-edge capture into sticky pending bits, served highest-index first
//   clk        in   1  clock
//   rst        in   1  synchronous active-high reset
//   i_req_in   in   N  request levels, synchronous to clk
//   i_mask     in   N  1 = line enabled for capture
//   i_ov_clr   in   1  clears all overflow bits
//   o_pending  out  N  registered pending vector
//   o_overflow out  N  sticky: edge arrived on a line already pending
//   out_if     master  valid/ready/idx channel
module irq_pending_capture
    import irq_pending_capture_pkg::*;
#(
    parameter  int N = N_DEFAULT,
    localparam int W = $clog2(N)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N-1:0]                 i_req_in,
    input  logic [N-1:0]                 i_mask,
    input  logic                         i_ov_clr,
    output logic [N-1:0]                 o_pending,
    output logic [N-1:0]                 o_overflow,
    irq_pending_capture_if.master        out_if
);
    state_t       r_state;
    state_t       w_state_nxt;
    logic [N-1:0] r_req_d;
    logic [N-1:0] r_pending;
    logic [N-1:0] r_overflow;
    logic         r_valid;
    logic [W-1:0] r_idx;
    logic         w_valid_nxt;
    logic [W-1:0] w_idx_nxt;
    logic [N-1:0] w_rise;
    logic [N-1:0] w_clr;
    logic [N-1:0] w_pending_nxt;
    logic [N-1:0] w_overflow_nxt;
    logic         w_hs;
    logic [W-1:0] w_pick_idx;
    logic         w_pick_any;

    prio_pick_n #(.N(N)) u_pick (
        .i_vec (r_pending),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    assign w_rise = i_req_in & ~r_req_d & i_mask;
    assign w_hs   = r_valid & out_if.ready;
    assign w_clr  = w_hs ? (N'(1) << r_idx) : '0;
    // OR-ing the rise after the clear lets a same-cycle re-edge keep the bit pending
    assign w_pending_nxt  = (r_pending & ~w_clr) | w_rise;
    // a new overflow outranks a simultaneous ov_clr
    assign w_overflow_nxt = (i_ov_clr ? '0 : r_overflow) | (w_rise & r_pending & ~w_clr);

    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_idx_nxt   = r_idx;
        if (r_state == ST_IDLE) begin
            if (w_pick_any) begin
                w_state_nxt = ST_PRESENT;
                w_valid_nxt = 1'b1;
                w_idx_nxt   = w_pick_idx;
            end
        end else if (w_hs) begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_req_d    <= '0;
            r_pending  <= '0;
            r_overflow <= '0;
            r_valid    <= 1'b0;
            r_idx      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_req_d    <= i_req_in;
            r_pending  <= w_pending_nxt;
            r_overflow <= w_overflow_nxt;
            r_valid    <= w_valid_nxt;
            r_idx      <= w_idx_nxt;
        end
    end

    assign o_pending    = r_pending;
    assign o_overflow   = r_overflow;
    assign out_if.valid = r_valid;
    assign out_if.idx   = r_idx;
endmodule

// File: tb/tb_irq_pending_capture.sv
// tb_irq_pending_capture: directed vectors with a per-cycle reference model and literal checkpoints
module tb_irq_pending_capture;
    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] mask;
    logic       ov_clr;
    logic [3:0] pending;
    logic [3:0] overflow;
    int         checks;
    int         errors;
    logic       chk_en;

    irq_pending_capture_if #(.N(4)) u_if ();

    irq_pending_capture #(.N(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_req_in   (req),
        .i_mask     (mask),
        .i_ov_clr   (ov_clr),
        .o_pending  (pending),
        .o_overflow (overflow),
        .out_if     (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] m_pend, m_ov, m_reqd, n_pend, n_ov;
    logic       m_valid, n_valid;
    logic [1:0] m_idx, n_idx;

    always_comb begin
        n_pend  = m_pend;
        n_ov    = ov_clr ? 4'b0 : m_ov;
        n_valid = m_valid;
        n_idx   = m_idx;
        for (int i = 0; i < 4; i++) begin
            if (m_valid && u_if.ready && int'(m_idx) == i) n_pend[i] = 1'b0;
            if (req[i] && !m_reqd[i] && mask[i]) begin
                if (m_pend[i] && !(m_valid && u_if.ready && int'(m_idx) == i)) n_ov[i] = 1'b1;
                n_pend[i] = 1'b1;
            end
        end
        if (m_valid) begin
            if (u_if.ready) n_valid = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (m_pend[i]) begin
                    n_valid = 1'b1;
                    n_idx   = 2'(i);
                end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m_pend  <= 4'b0;
            m_ov    <= 4'b0;
            m_reqd  <= 4'b0;
            m_valid <= 1'b0;
            m_idx   <= 2'b0;
        end else begin
            m_pend  <= n_pend;
            m_ov    <= n_ov;
            m_reqd  <= req;
            m_valid <= n_valid;
            m_idx   <= n_idx;
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_valid", {7'b0, u_if.valid}, {7'b0, m_valid});
            chk("model_pending", {4'b0, pending}, {4'b0, m_pend});
            chk("model_overflow", {4'b0, overflow}, {4'b0, m_ov});
            if (m_valid) chk("model_idx", {6'b0, u_if.idx}, {6'b0, m_idx});
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_out(input string name, input logic v, input logic [1:0] idx,
                              input logic [3:0] p, input logic [3:0] o);
        chk({name, "_valid"}, {7'b0, u_if.valid}, {7'b0, v});
        if (v) chk({name, "_idx"}, {6'b0, u_if.idx}, {6'b0, idx});
        chk({name, "_pending"}, {4'b0, pending}, {4'b0, p});
        chk({name, "_overflow"}, {4'b0, overflow}, {4'b0, o});
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        chk_en    = 1'b0;
        rst       = 1'b1;
        req       = 4'b0;
        mask      = 4'hF;
        ov_clr    = 1'b0;
        u_if.ready = 1'b1;
        step(2);
        rst    = 1'b0;
        chk_en = 1'b1;
        expect_out("reset", 1'b0, 2'd0, 4'b0000, 4'b0000);
        chk("reset_idx", {6'b0, u_if.idx}, 8'h0);

        req = 4'b0100; step(1);
        expect_out("t1_cap", 1'b0, 2'd0, 4'b0100, 4'b0000);
        req = 4'b0000; step(1);
        expect_out("t1_pres", 1'b1, 2'd2, 4'b0100, 4'b0000);
        step(1);
        expect_out("t1_done", 1'b0, 2'd0, 4'b0000, 4'b0000);

        req = 4'b1001; step(1);
        expect_out("t2_cap", 1'b0, 2'd0, 4'b1001, 4'b0000);
        req = 4'b0000; step(1);
        expect_out("t2_first", 1'b1, 2'd3, 4'b1001, 4'b0000);
        step(1);
        expect_out("t2_bubble", 1'b0, 2'd0, 4'b0001, 4'b0000);
        step(1);
        expect_out("t2_second", 1'b1, 2'd0, 4'b0001, 4'b0000);
        step(1);
        expect_out("t2_done", 1'b0, 2'd0, 4'b0000, 4'b0000);

        mask = 4'b1101; req = 4'b0010; step(1);
        expect_out("t3_masked", 1'b0, 2'd0, 4'b0000, 4'b0000);
        req = 4'b0000; mask = 4'hF; step(2);
        expect_out("t3_unmask", 1'b0, 2'd0, 4'b0000, 4'b0000);

        u_if.ready = 1'b0; req = 4'b0010; step(1);
        req = 4'b0000; step(1);
        expect_out("t4_pres", 1'b1, 2'd1, 4'b0010, 4'b0000);
        req = 4'b1010; step(1);
        expect_out("t4_ovf", 1'b1, 2'd1, 4'b1010, 4'b0010);
        req = 4'b0000; step(2);
        expect_out("t4_hold", 1'b1, 2'd1, 4'b1010, 4'b0010);
        u_if.ready = 1'b1; step(1);
        expect_out("t4_hs", 1'b0, 2'd0, 4'b1000, 4'b0010);
        step(1);
        expect_out("t4_next", 1'b1, 2'd3, 4'b1000, 4'b0010);
        step(1);
        ov_clr = 1'b1; step(1);
        ov_clr = 1'b0;
        expect_out("t4_ovclr", 1'b0, 2'd0, 4'b0000, 4'b0000);

        u_if.ready = 1'b0; req = 4'b0100; step(1);
        req = 4'b0000; step(1);
        expect_out("t5_pres", 1'b1, 2'd2, 4'b0100, 4'b0000);
        u_if.ready = 1'b1; req = 4'b0100; step(1);
        expect_out("t5_collide", 1'b0, 2'd0, 4'b0100, 4'b0000);
        req = 4'b0000; step(1);
        expect_out("t5_again", 1'b1, 2'd2, 4'b0100, 4'b0000);
        step(1);
        expect_out("t5_done", 1'b0, 2'd0, 4'b0000, 4'b0000);

        u_if.ready = 1'b0; req = 4'b1000; step(2);
        expect_out("t6_pres", 1'b1, 2'd3, 4'b1000, 4'b0000);
        rst = 1'b1; step(1);
        expect_out("t6_rst", 1'b0, 2'd0, 4'b0000, 4'b0000);
        chk("t6_rst_idx", {6'b0, u_if.idx}, 8'h0);
        rst = 1'b0; step(1);
        expect_out("t6_recap", 1'b0, 2'd0, 4'b1000, 4'b0000);
        step(1);
        expect_out("t6_pres2", 1'b1, 2'd3, 4'b1000, 4'b0000);
        u_if.ready = 1'b1; step(1);
        expect_out("t6_done", 1'b0, 2'd0, 4'b0000, 4'b0000);
        req = 4'b0000; step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
